osd_overlay: RTL
================

OSD_OVERLAY -- requirements
Module: osd_overlay

Interface
REQ-001 Parameter H_START, default 120: CLK cycles from HSync falling edge to the first OSD pixel.
REQ-002 Parameter V_START, default 256: HSync falling edges from VSync falling edge to the first OSD line.
REQ-003 Parameter OSD_COLOR, default 3'b110: {R,G,B} enables for lit OSD pixels.
REQ-004 CLK  in  1  14 MHz video clock, the same clock as the video generator; the sole clock of the block.
REQ-005 RESET  in  1  asynchronous, active-high reset.
REQ-006 SPI_SCK  in  1  SPI clock from the IO controller, asynchronous to CLK, at most CLK/4.
REQ-007 SPI_SS3  in  1  SPI select, active low.
REQ-008 SPI_DI  in  1  SPI data, MSB first, sampled on the SPI_SCK rising edge.
REQ-009 R_in/G_in/B_in  in  6 each  video colour from the video generator.
REQ-010 HSync/VSync  in  1 each  active-low OSD syncs from the video generator.
REQ-011 R_out/G_out/B_out  out  6 each  overlaid colour.
REQ-012 HS_out/VS_out  out  1 each  HSync/VSync delayed to match the colour outputs.

Function
REQ-013 SPI_SCK, SPI_SS3 and SPI_DI SHALL pass through 2-FF synchronisers; an SCK rise SHALL be detected as the synchronised signal going 0->1.
REQ-014 The SPI receiver SHALL shift one bit per SCK rise while SS is low; a byte SHALL complete on the 8th bit.
REQ-015 An SS high level SHALL clear the bit counter, discard any partial byte and return the command FSM to IDLE.
REQ-016 Command FSM states: IDLE, WRITE, IGNORE; the first byte after SS falls is the command.
REQ-017 Command 0x41 SHALL set osd_enable=1; command 0x40 SHALL clear it; both commands go to IGNORE.
REQ-018 Command 0x20|r, with r in 0..7, SHALL set row=r and col=0 and go to WRITE.
REQ-019 All other commands SHALL go to IGNORE; bytes received in IGNORE are discarded.
REQ-020 In WRITE, each byte SHALL be written to buffer address {row,col}, then col SHALL increment.
REQ-021 col SHALL wrap from 255 to 0 within the same row.
REQ-022 h_cnt (9 bit) SHALL clear on the HSync falling edge and otherwise increment, saturating at 511.
REQ-023 v_cnt (10 bit) SHALL increment on each HSync falling edge, saturating at 1023.
REQ-024 v_cnt SHALL clear on the VSync falling edge; if both edges fall in the same cycle, the clear wins.
REQ-025 The window SHALL be H_START <= h_cnt < H_START+256 and V_START <= v_cnt < V_START+128.
REQ-026 Window coordinates: x = h_cnt-H_START (8 bit) and y = (v_cnt-V_START)>>1 (6 bit), so each OSD row spans two scanlines.
REQ-027 The buffer read address SHALL be {y[5:3], x}; the pixel SHALL be bit y[2:0] of the read data.
REQ-028 Outside the window, or when osd_enable=0, the outputs SHALL equal the inputs.
REQ-029 A lit pixel inside the window SHALL drive each channel to 6'h3F when its OSD_COLOR bit is 1, otherwise 6'h00.
REQ-030 An unlit pixel inside the window SHALL output R=R_in>>1, G=G_in>>1 and B=(B_in>>1)|6'h20.
REQ-031 Colour and sync outputs SHALL be registered, with a fixed latency of 2 CLK from the inputs: 1 cycle of RAM read plus 1 output register.
REQ-032 A buffer write and a read of the same address in the same cycle SHALL return the old data.
REQ-033 osd_enable changes SHALL take effect on the next cycle, mid-frame included; no frame alignment is required.

Reset
REQ-034 RESET SHALL clear osd_enable, the FSM (to IDLE), the bit counter, row, col, h_cnt, v_cnt, all outputs (colours 0) and the sync pipeline.
REQ-035 Sync outputs SHALL reset to 1 (inactive).
REQ-036 Buffer contents SHALL NOT be reset.
REQ-037 A reset mid-byte SHALL abandon the transfer, with no buffer write.

Structure
REQ-038 Package osd_pkg SHALL hold the command codes (CMD_ENABLE 0x41, CMD_DISABLE 0x40, CMD_WRITE_BASE 0x20), the OSD width 256, the OSD height 64 and the buffer depth 2048.
REQ-039 Sub-module osd_buffer SHALL be a 2048x8 simple dual-port RAM with synchronous read and a single clock CLK.

Verification
REQ-040 After reset, send SPI 0x41 then raise SS -> osd_enable=1; outside the window, outputs equal the inputs delayed by 2 CLK.
REQ-041 Send SPI 0x23 then 0xFF,0x01 -> buffer[0x300]=0xFF and buffer[0x301]=0x01; the pixels at x=0 and x=1 for y=24 are lit, R/G=6'h3F and B=0.
REQ-042 Send 0x20 then 257 bytes, the last one 0xAA -> col wraps, buffer[0x000]=0xAA, and row 1 is untouched.
REQ-043 Raise SS after 5 bits of a data byte -> no write occurs; the next command after SS falls is decoded correctly.
REQ-044 Unlit pixel with input R/G/B=6'h3F -> output R=G=6'h1F, B=6'h3F; after sending 0x40 the same pixel passes through unchanged.
REQ-045 Assert RESET mid-line while the window is active -> all colour outputs are 0 and syncs are 1 immediately; after release, the OSD is disabled and the buffer data is retained.

Source files
------------

// File: rtl/osd_pkg.sv
// Shared constants for the OSD overlay: SPI command codes, OSD geometry,
// buffer sizing, command FSM encodings and the registered video bundle.
package osd_pkg;

  localparam logic [7:0] CMD_ENABLE     = 8'h41;
  localparam logic [7:0] CMD_DISABLE    = 8'h40;
  localparam logic [7:0] CMD_WRITE_BASE = 8'h20;

  localparam int OSD_W     = 256;
  localparam int OSD_H     = 64;
  localparam int BUF_DEPTH = 2048;
  localparam int ADDR_W    = $clog2(BUF_DEPTH);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WRITE  = 2'd1;
  localparam logic [1:0] ST_IGNORE = 2'd2;

  typedef struct packed {
    logic [5:0] r;
    logic [5:0] g;
    logic [5:0] b;
    logic       hs;
    logic       vs;
  } video_t;

  // Write commands occupy 0x20..0x27; the low three bits select the row.
  function automatic logic is_write_cmd(input logic [7:0] cmd);
    return cmd[7:3] == CMD_WRITE_BASE[7:3];
  endfunction

endpackage

// File: rtl/osd_buffer.sv
// OSD character-cell buffer: simple dual-port RAM, one write port and one
// synchronous read port on the video clock.
module osd_buffer
  import osd_pkg::*;
(
  input  logic              CLK,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [BUF_DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; a read colliding
  // with a write returns the old word because the write is non-blocking.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/osd_overlay.sv
// On-screen-display overlay: an SPI-loaded 256x64 bitmap is blended over
// the incoming video with a fixed two-clock pipeline.
module osd_overlay
  import osd_pkg::*;
#(
  parameter int         H_START   = 120,
  parameter int         V_START   = 256,
  parameter logic [2:0] OSD_COLOR = 3'b110
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       SPI_SCK,
  input  logic       SPI_SS3,
  input  logic       SPI_DI,
  input  logic [5:0] R_in,
  input  logic [5:0] G_in,
  input  logic [5:0] B_in,
  input  logic       HSync,
  input  logic       VSync,
  output logic [5:0] R_out,
  output logic [5:0] G_out,
  output logic [5:0] B_out,
  output logic       HS_out,
  output logic       VS_out
);

  localparam logic [8:0] H_LO = 9'(H_START);
  localparam logic [8:0] H_HI = 9'(H_START + OSD_W);
  localparam logic [9:0] V_LO = 10'(V_START);
  localparam logic [9:0] V_HI = 10'(V_START + 2 * OSD_H);

  // ---------------- SPI receiver and command FSM ----------------
  logic [2:0] sck_sr;
  logic [1:0] ss_sr, di_sr;
  logic [2:0] bit_cnt;
  logic [6:0] shift;
  logic [1:0] state;
  logic [2:0] row;
  logic [7:0] col;
  logic       osd_enable;

  logic       sck_rise, ss, byte_done;
  logic [7:0] rx_byte;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sck_sr <= '0;
      ss_sr  <= '1;
      di_sr  <= '0;
    end else begin
      sck_sr <= {sck_sr[1:0], SPI_SCK};
      ss_sr  <= {ss_sr[0], SPI_SS3};
      di_sr  <= {di_sr[0], SPI_DI};
    end
  end

  assign sck_rise  = sck_sr[1] & ~sck_sr[2];
  assign ss        = ss_sr[1];
  assign rx_byte   = {shift, di_sr[1]};
  assign byte_done = sck_rise && !ss && (bit_cnt == 3'd7);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      bit_cnt    <= '0;
      shift      <= '0;
      state      <= ST_IDLE;
      row        <= '0;
      col        <= '0;
      osd_enable <= 1'b0;
    end else if (ss) begin
      bit_cnt <= '0;
      shift   <= '0;
      state   <= ST_IDLE;
    end else if (sck_rise) begin
      bit_cnt <= bit_cnt + 3'd1;
      shift   <= rx_byte[6:0];
      if (bit_cnt == 3'd7) begin
        case (state)
          ST_IDLE: begin
            if (rx_byte == CMD_ENABLE) begin
              osd_enable <= 1'b1;
              state      <= ST_IGNORE;
            end else if (rx_byte == CMD_DISABLE) begin
              osd_enable <= 1'b0;
              state      <= ST_IGNORE;
            end else if (is_write_cmd(rx_byte)) begin
              row   <= rx_byte[2:0];
              col   <= '0;
              state <= ST_WRITE;
            end else begin
              state <= ST_IGNORE;
            end
          end
          ST_WRITE: col <= col + 8'd1;  // wraps inside the row
          default:  state <= ST_IGNORE;
        endcase
      end
    end
  end

  // ---------------- Raster counters ----------------
  logic       hs_d, vs_d, hs_fall, vs_fall;
  logic [8:0] h_cnt;
  logic [9:0] v_cnt;

  assign hs_fall = hs_d & ~HSync;
  assign vs_fall = vs_d & ~VSync;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hs_d  <= 1'b1;
      vs_d  <= 1'b1;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      hs_d <= HSync;
      vs_d <= VSync;
      if (hs_fall)            h_cnt <= '0;
      else if (h_cnt != '1)   h_cnt <= h_cnt + 9'd1;
      if (vs_fall)            v_cnt <= '0;
      else if (hs_fall && v_cnt != '1) v_cnt <= v_cnt + 10'd1;
    end
  end

  // ---------------- Window decode and buffer ----------------
  logic              in_win;
  logic [7:0]        x;
  logic [5:0]        y;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    in_win  = 1'b0;
    x       = 8'(h_cnt - H_LO);
    y       = 6'((v_cnt - V_LO) >> 1);
    rd_addr = {y[5:3], x};
    if (h_cnt >= H_LO && h_cnt < H_HI && v_cnt >= V_LO && v_cnt < V_HI)
      in_win = 1'b1;
  end

  osd_buffer u_buffer (
    .CLK     (CLK),
    .wr_en   (byte_done && state == ST_WRITE),
    .wr_addr ({row, col}),
    .wr_data (rx_byte),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // ---------------- Two-stage video pipeline ----------------
  video_t     s1_vid;
  logic       s1_active;
  logic [2:0] s1_bit;
  logic       lit;

  assign lit = rd_data[s1_bit];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      s1_vid    <= '{r: '0, g: '0, b: '0, hs: 1'b1, vs: 1'b1};
      s1_active <= 1'b0;
      s1_bit    <= '0;
      R_out     <= '0;
      G_out     <= '0;
      B_out     <= '0;
      HS_out    <= 1'b1;
      VS_out    <= 1'b1;
    end else begin
      s1_vid    <= '{r: R_in, g: G_in, b: B_in, hs: HSync, vs: VSync};
      s1_active <= in_win && osd_enable;
      s1_bit    <= y[2:0];
      HS_out    <= s1_vid.hs;
      VS_out    <= s1_vid.vs;
      if (!s1_active) begin
        R_out <= s1_vid.r;
        G_out <= s1_vid.g;
        B_out <= s1_vid.b;
      end else if (lit) begin
        R_out <= {6{OSD_COLOR[2]}};
        G_out <= {6{OSD_COLOR[1]}};
        B_out <= {6{OSD_COLOR[0]}};
      end else begin
        // Unlit cells dim the picture and tint it blue for a backdrop.
        R_out <= {1'b0, s1_vid.r[5:1]};
        G_out <= {1'b0, s1_vid.g[5:1]};
        B_out <= {1'b1, s1_vid.b[5:1]};
      end
    end
  end

endmodule
